game_tick_scheduler: RTL and testbench

Central tick controller for the game logic. It owns the free-running divider counter and runs a start/pause/step/stop state machine that gates it. It also issues single-cycle tick enables to NUM_CH consumers (bird physics, pipe scroll, score/blink). Each channel selects its own divider tap at run time, and a global speed level shortens all periods as the game progresses.

---
 rtl/game_tick_scheduler.sv | 147 ++++++++++++++
 tb/tb_game_tick_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Tick controller for the game logic: free-running divider gated by an IDLE/RUN/PAUSE/STEP FSM.
// Optional feature macro: TICK_SCHED_SPEEDUP_EN enables the speed_up input and the speed_level shortening.
module game_tick_scheduler #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_TAP = 23,
    parameter int MIN_TAP     = 1,
    parameter int MAX_SPEED   = 4,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int TAP_W      = $clog2(CNT_W),
    localparam int SPD_W      = $clog2(MAX_SPEED + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    input  logic              stop,
    input  logic              speed_up,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [TAP_W-1:0]  cfg_tap,
    output logic [NUM_CH-1:0] tick,
    output logic              running,
    output logic [SPD_W-1:0]  speed_level,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_STEP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_CH-1:0]  tick_q, tick_d;
    logic               running_q, running_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic [TAP_W-1:0]   tap_q [NUM_CH];
    logic [TAP_W-1:0]   tap_d [NUM_CH];
    logic [TAP_W-1:0]   tap_wr;

    // Effective tap: stored tap lowered by the speed level, floored at MIN_TAP.
    function automatic logic [TAP_W-1:0] eff_tap(input logic [TAP_W-1:0] tap,
                                                  input logic [SPD_W-1:0] spd);
        int t;
        t = int'(tap) - int'(spd);
        if (t < MIN_TAP) t = MIN_TAP;
        return TAP_W'(t);
    endfunction

    // True when cnt[e:0] == 2^e; one extra bit keeps the mask exact for e = CNT_W-1.
    function automatic logic tap_hit(input logic [CNT_W-1:0] cnt,
                                     input logic [TAP_W-1:0] e);
        logic [CNT_W:0] one;
        logic [CNT_W:0] mask;
        one  = (CNT_W + 1)'(1) << e;
        mask = (one << 1) - (CNT_W + 1)'(1);
        return ({1'b0, cnt} & mask) == one;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN:   if (pause) state_d = S_PAUSE;
                S_PAUSE: begin
                    if (start)     state_d = S_RUN;
                    else if (step) state_d = S_STEP;
                end
                S_STEP:  state_d = S_PAUSE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d   = count_q;
        tick_d    = '0;
        running_d = (state_d == S_RUN);
        if (state_d == S_IDLE) begin
            count_d = '0;
        end else if (state_q == S_RUN && state_d == S_RUN) begin
            // Ticks are judged on the incremented count so they line up with the registered count.
            count_d = count_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                tick_d[i] = tap_hit(count_d, eff_tap(tap_q[i], speed_q));
            end
        end else if (state_d == S_STEP) begin
            tick_d = '1;
        end
    end

`ifdef TICK_SCHED_SPEEDUP_EN
    always_comb begin
        speed_d = speed_q;
        if (speed_up && speed_q != SPD_W'(MAX_SPEED)) speed_d = speed_q + 1'b1;
    end
`else
    logic unused_speed_up;
    assign unused_speed_up = speed_up;

    always_comb begin
        speed_d = '0;
    end
`endif

    always_comb begin
        tap_wr = (int'(cfg_tap) > CNT_W - 1) ? TAP_W'(CNT_W - 1) : cfg_tap;
        tap_d  = tap_q;
        if (cfg_wr && int'(cfg_ch) < NUM_CH) tap_d[cfg_ch] = tap_wr;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            tick_q    <= '0;
            running_q <= 1'b0;
            speed_q   <= '0;
            // NOTE: the tap table is small and has a defined power-up value, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                tap_q[i] <= TAP_W'(DEFAULT_TAP);
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            speed_q   <= speed_d;
            tap_q     <= tap_d;
        end
    end

    assign tick        = tick_q;
    assign running     = running_q;
    assign speed_level = speed_q;
    assign count       = count_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with DEFAULT_TAP = 3, NUM_CH = 3, CNT_W = 32.
// Expectations follow TICK_SCHED_SPEEDUP_EN when it is defined for the build.
module tb_game_tick_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic        step;
    logic        stop;
    logic        speed_up;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [4:0]  cfg_tap;
    logic [2:0]  tick;
    logic        running;
    logic [2:0]  speed_level;
    logic [31:0] count;

    int total = 0;
    int bad   = 0;
    int exp_spd = 0;
    int eff_all;

    game_tick_scheduler #(
        .NUM_CH      (3),
        .CNT_W       (32),
        .DEFAULT_TAP (3),
        .MIN_TAP     (1),
        .MAX_SPEED   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .step        (step),
        .stop        (stop),
        .speed_up    (speed_up),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_tap     (cfg_tap),
        .tick        (tick),
        .running     (running),
        .speed_level (speed_level),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_in();
        start    = 1'b0;
        pause    = 1'b0;
        step     = 1'b0;
        stop     = 1'b0;
        speed_up = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_tap  = '0;
    endtask

    // Channel with effective tap e ticks when count mod 2^(e+1) == 2^e.
    function automatic logic [2:0] exp_tick(input int k, input int e0, input int e1, input int e2);
        logic [2:0] r;
        int e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < 3; i++) begin
            r[i] = ((longint'(k) % (longint'(2) << e[i])) == (longint'(1) << e[i]));
        end
        return r;
    endfunction

    task automatic cfg(input logic [1:0] ch, input logic [4:0] tap);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_tap = tap;
        cyc();
        cfg_wr = 1'b0;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_running", running, 0);
        check("rst_count", count, 0);
        check("rst_tick", tick, 0);
        check("rst_speed", speed_level, 0);
        cyc();
        check("idle_count", count, 0);

        // Start from IDLE: first RUN cycle shows count 0, ticks at 8 then every 16.
        start = 1'b1; cyc(); start = 1'b0;
        check("start_running", running, 1);
        check("start_count", count, 0);
        check("start_tick", tick, 0);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            check("run_count", count, k);
            check("run_tick", tick, exp_tick(k, 3, 3, 3));
        end

        // Retap channel 1 to 1 while running: period 4 from here, others unchanged.
        cfg(2'd1, 5'd1);
        check("cfg_count", count, 31);
        check("cfg_tick", tick, 0);
        for (int k = 32; k <= 60; k++) begin
            cyc();
            check("tap1_count", count, k);
            check("tap1_tick", tick, exp_tick(k, 3, 1, 3));
        end

        stop = 1'b1; cyc(); stop = 1'b0;
        check("stop_running", running, 0);
        check("stop_count", count, 0);
        check("stop_tick", tick, 0);
        cfg(2'd1, 5'd3);

        // Run to 20, pause, step twice, resume.
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_count", count, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check("pre_pause_tick", tick, exp_tick(k, 3, 3, 3));
        end
        check("pre_pause_count", count, 20);
        pause = 1'b1; cyc(); pause = 1'b0;
        check("pause_running", running, 0);
        check("pause_count", count, 20);
        check("pause_tick", tick, 0);
        cyc();
        check("pause_hold_count", count, 20);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1; cyc(); step = 1'b0;
            check("step_tick", tick, 3'b111);
            check("step_count", count, 20);
            check("step_running", running, 0);
            cyc();
            check("post_step_tick", tick, 0);
            check("post_step_count", count, 20);
        end
        start = 1'b1; cyc(); start = 1'b0;
        check("resume_running", running, 1);
        check("resume_count", count, 20);
        check("resume_tick", tick, 0);
        for (int k = 21; k <= 24; k++) begin
            cyc();
            check("resume_cnt", count, k);
            check("resume_tk", tick, exp_tick(k, 3, 3, 3));
        end

        // Speed-up while paused, then run with the shortened period.
        pause = 1'b1; cyc(); pause = 1'b0;
        check("pause2_count", count, 24);
        for (int i = 1; i <= 6; i++) begin
            speed_up = 1'b1; cyc(); speed_up = 1'b0;
`ifdef TICK_SCHED_SPEEDUP_EN
            exp_spd = (i > 4) ? 4 : i;
`else
            exp_spd = 0;
`endif
            check("speed_level", speed_level, exp_spd);
        end
`ifdef TICK_SCHED_SPEEDUP_EN
        eff_all = 1;
`else
        eff_all = 3;
`endif
        start = 1'b1; cyc(); start = 1'b0;
        check("fast_first_count", count, 24);
        check("fast_first_tick", tick, 0);
        for (int k = 25; k <= 44; k++) begin
            cyc();
            check("fast_count", count, k);
            check("fast_tick", tick, exp_tick(k, eff_all, eff_all, eff_all));
        end

        // Stop and start together: stop wins.
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        check("ss_running", running, 0);
        check("ss_count", count, 0);
        check("ss_tick", tick, 0);
        cyc();
        check("ss_hold_count", count, 0);
        check("ss_speed_kept", speed_level, exp_spd);

        // Reset in the middle of a STEP cycle.
        cfg(2'd2, 5'd1);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        check("pre_step_count", count, 5);
        pause = 1'b1; cyc(); pause = 1'b0;
        step = 1'b1; cyc(); step = 1'b0;
        check("step2_tick", tick, 3'b111);
        check("step2_count", count, 5);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("rst_step_tick", tick, 0);
        check("rst_step_running", running, 0);
        check("rst_step_count", count, 0);
        check("rst_step_speed", speed_level, 0);

        // Out-of-range channel is ignored; tap 31 is the widest and never fires here.
        cfg(2'd3, 5'd1);
        cfg(2'd0, 5'd31);
        start = 1'b1; cyc(); start = 1'b0;
        check("cfg_start_count", count, 0);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            check("cfg_run_tick", tick, exp_tick(k, 31, 3, 3));
        end
        check("cfg_run_count", count, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
